// File: rtl/instr_cache.sv
`default_nettype none
// ============================================================================
//  Module   : instr_cache
//  Desc     : Direct-mapped read-only instruction cache with whole-line refill
//             from instruction memory; misses stall the fetch via BUSYWAIT.
//             Optional hit/miss statistics when ICACHE_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_cache #(
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_LINES  = 8,
    parameter int LINE_WORDS = 4,
    localparam int C_IDX_W   = $clog2(NUM_LINES),
    localparam int C_OFF_W   = $clog2(LINE_WORDS),
    localparam int C_TAG_W   = ADDR_WIDTH - C_IDX_W - C_OFF_W - 2,
    localparam int C_BLK_W   = C_TAG_W + C_IDX_W,
    localparam int C_LINE_W  = LINE_WORDS * 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic [C_BLK_W-1:0]    MEM_ADDRESS,
    input  logic [C_LINE_W-1:0]   MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]           HIT_COUNT,
    output logic [15:0]           MISS_COUNT
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [C_TAG_W-1:0]  w_tag;
    logic [C_IDX_W-1:0]  w_index;
    logic [C_OFF_W-1:0]  w_offset;

    logic [NUM_LINES-1:0] r_valid;
    logic [C_TAG_W-1:0]   r_tag  [NUM_LINES];
    logic [C_LINE_W-1:0]  r_data [NUM_LINES];

    logic [C_BLK_W-1:0]  r_req_blk;
    logic [C_LINE_W-1:0] r_fill_data;
    logic [C_TAG_W-1:0]  w_req_tag;
    logic [C_IDX_W-1:0]  w_req_index;

    logic                w_hit;
    logic [31:0]         w_word;

    assign w_tag       = ADDRESS[ADDR_WIDTH-1 -: C_TAG_W];
    assign w_index     = ADDRESS[C_OFF_W+2 +: C_IDX_W];
    assign w_offset    = ADDRESS[2 +: C_OFF_W];
    assign w_req_tag   = r_req_blk[C_BLK_W-1 -: C_TAG_W];
    assign w_req_index = r_req_blk[C_IDX_W-1:0];

    assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_word = r_data[w_index][{w_offset, 5'd0} +: 32];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        BUSYWAIT     = 1'b0;
        MEM_READ     = 1'b0;
        MEM_ADDRESS  = '0;
        INSTRUCTION  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    INSTRUCTION = w_word;
                end else begin
                    BUSYWAIT     = 1'b1;
                    w_next_state = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = r_req_blk;
                if (!MEM_BUSYWAIT) begin
                    w_next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                BUSYWAIT     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        // Reset forces a quiet fetch port regardless of the current state
        if (!RESET) begin
            BUSYWAIT    = 1'b0;
            MEM_READ    = 1'b0;
            MEM_ADDRESS = '0;
            INSTRUCTION = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_valid <= '0;
        end else if (r_state == S_UPDATE) begin
            r_valid[w_req_index] <= 1'b1;
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it
    always_ff @(posedge CLK) begin
        if (r_state == S_IDLE && !w_hit) begin
            r_req_blk <= {w_tag, w_index};
        end
        if (r_state == S_MEM_READ && !MEM_BUSYWAIT) begin
            r_fill_data <= MEM_READDATA;
        end
        if (RESET && r_state == S_UPDATE) begin
            r_data[w_req_index] <= r_fill_data;
            r_tag[w_req_index]  <= w_req_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0]           r_hit_count;
    logic [15:0]           r_miss_count;
    logic [ADDR_WIDTH-1:0] r_last_hit_addr;

    // A hit held over several cycles on one address is counted once
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_hit_count     <= '0;
            r_miss_count    <= '0;
            r_last_hit_addr <= '1;
        end else if (r_state == S_IDLE) begin
            if (w_hit) begin
                if (ADDRESS != r_last_hit_addr && r_hit_count != 16'hFFFF) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
                r_last_hit_addr <= ADDRESS;
            end else if (r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign HIT_COUNT  = r_hit_count;
    assign MISS_COUNT = r_miss_count;
`else
    // Byte-lane bits only matter to the hit-address tracking of the stats build
    logic w_unused;
    assign w_unused = &{1'b0, ADDRESS[1:0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_cache
//  Desc     : Self-checking bench for instr_cache against a line-level model
//             with a programmable-latency memory image.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_cache;

    logic         CLK;
    logic         RESET;
    logic [9:0]   ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] mem_img [64];
    logic         m_valid [8];
    logic [2:0]   m_tag   [8];

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_of(input logic [9:0] a);
        logic [127:0] b;
        b = mem_img[a[9:4]];
        return b[a[3:2]*32 +: 32];
    endfunction

    function automatic logic model_hit(input logic [9:0] a);
        return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Holds RESET low for n edges, then releases it right after an edge
    task automatic apply_reset(input int n);
        RESET = 1'b0;
        for (int i = 0; i < n; i++) begin
            ADDRESS      = 10'($urandom);
            MEM_BUSYWAIT = 1'($urandom);
            MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
            @(negedge CLK);
            vectors++;
            if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'd0 || INSTRUCTION !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: busywait=%b mem_read=%b mem_addr=%h instr=%h, required all zero",
                         BUSYWAIT, MEM_READ, MEM_ADDRESS, INSTRUCTION);
            end
            step();
        end
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        RESET = 1'b1;
    endtask

    // One fetch: hit checked in place, miss walked through request/fill/update
    task automatic do_access(input logic [9:0] a, input int lat);
        logic [5:0]   blk;
        logic [127:0] junk;
        blk  = a[9:4];
        junk = {$urandom, $urandom, $urandom, $urandom};
        ADDRESS      = a;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = junk;
        @(negedge CLK);
        vectors++;
        if (model_hit(a)) begin
            if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || INSTRUCTION !== word_of(a)) begin
                miscompares++;
                $display("FAIL hit@%h: busywait=%b mem_read=%b instr=%h, required 0 0 %h",
                         a, BUSYWAIT, MEM_READ, INSTRUCTION, word_of(a));
            end
            step();
            return;
        end
        if (BUSYWAIT !== 1'b1 || INSTRUCTION !== 32'd0) begin
            miscompares++;
            $display("FAIL miss_detect@%h: busywait=%b instr=%h, required 1 00000000",
                     a, BUSYWAIT, INSTRUCTION);
        end
        step();
        for (int k = 0; k < lat; k++) begin
            MEM_BUSYWAIT = (k != lat - 1);
            MEM_READDATA = (k == lat - 1) ? mem_img[blk] : junk;
            @(negedge CLK);
            vectors++;
            if (MEM_READ !== 1'b1 || MEM_ADDRESS !== blk || BUSYWAIT !== 1'b1) begin
                miscompares++;
                $display("FAIL mem_request@%h cyc%0d: mem_read=%b mem_addr=%h busywait=%b, required 1 %h 1",
                         a, k, MEM_READ, MEM_ADDRESS, BUSYWAIT, blk);
            end
            step();
        end
        MEM_BUSYWAIT = 1'($urandom);
        MEM_READDATA = junk;
        @(negedge CLK);
        vectors++;
        if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin
            miscompares++;
            $display("FAIL update@%h: busywait=%b mem_read=%b, required 1 0", a, BUSYWAIT, MEM_READ);
        end
        step();
        m_valid[a[6:4]] = 1'b1;
        m_tag[a[6:4]]   = a[9:7];
        @(negedge CLK);
        vectors++;
        if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || INSTRUCTION !== word_of(a)) begin
            miscompares++;
            $display("FAIL post_fill@%h: busywait=%b mem_read=%b instr=%h, required 0 0 %h",
                     a, BUSYWAIT, MEM_READ, INSTRUCTION, word_of(a));
        end
        step();
    endtask

    task automatic test_reset;
        apply_reset(3);
    endtask

    task automatic test_first_fill;
        do_access(10'h000, 5);
    endtask

    task automatic test_block0_hits;
        do_access(10'h004, 1);
        do_access(10'h008, 1);
        do_access(10'h00C, 1);
        do_access(10'h007, 1);
        vectors++;
        if (INSTRUCTION !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL byte_lane_0x007: instr=%h, required 00000004", INSTRUCTION);
        end
    endtask

    task automatic test_conflict;
        do_access(10'h080, 3);
        do_access(10'h000, 2);
    endtask

    task automatic test_reset_mid_fill;
        ADDRESS      = 10'h100;
        MEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        vectors++;
        if (BUSYWAIT !== 1'b1) begin
            miscompares++;
            $display("FAIL midfill_miss: busywait=%b, required 1", BUSYWAIT);
        end
        step();
        @(negedge CLK);
        vectors++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h10) begin
            miscompares++;
            $display("FAIL midfill_request: mem_read=%b mem_addr=%h, required 1 10", MEM_READ, MEM_ADDRESS);
        end
        step();
        RESET = 1'b0;
        step();
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = mem_img[6'h10];
        @(negedge CLK);
        vectors++;
        if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("FAIL midfill_reset: mem_read=%b busywait=%b, required 0 0", MEM_READ, BUSYWAIT);
        end
        step();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        RESET = 1'b1;
        do_access(10'h000, 2);
        do_access(10'h104, 2);
    endtask

    task automatic test_random;
        logic [9:0] a;
        for (int n = 0; n < 60; n++) begin
            a = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 4'($urandom)};
            do_access(a, $urandom_range(1, 4));
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats;
        apply_reset(1);
        do_access(10'h000, 2);
        do_access(10'h004, 1);
        do_access(10'h008, 1);
        ADDRESS = 10'h080;
        step();
        @(negedge CLK);
        vectors++;
        if (MISS_COUNT !== 16'd2 || HIT_COUNT !== 16'd3) begin
            miscompares++;
            $display("FAIL stats_sequence: miss=%0d hit=%0d, required 2 3", MISS_COUNT, HIT_COUNT);
        end
        apply_reset(1);
        do_access(10'h000, 1);
        force dut.r_hit_count = 16'hFFFF;
        step();
        release dut.r_hit_count;
        ADDRESS = 10'h004;
        step();
        @(negedge CLK);
        vectors++;
        if (HIT_COUNT !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stats_saturate: hit=%h, required FFFF", HIT_COUNT);
        end
        step();
    endtask
`endif

    initial begin
        RESET        = 1'b0;
        ADDRESS      = '0;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '0;
        for (int i = 0; i < 64; i++) mem_img[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_img[0] = 128'h0000000C_00000008_00000004_00000000;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end

        test_reset();
        test_first_fill();
        test_block0_hits();
        test_conflict();
        test_reset_mid_fill();
        test_random();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
